// File: rtl/ucount_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucount_pkg
// Description : Shared definitions for the stochastic-to-binary converter.
//               Holds the FSM state encoding and a window-length helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ucount_pkg;

  // FSM state encoding (2-bit, legacy-compatible constants)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

  // Number of enabled samples in one conversion window
  function automatic int unsigned win_len(input int unsigned winlog);
    return 32'd1 << winlog;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucount_b2c.sv
`default_nettype none
// ============================================================================
// Module      : ucount_b2c
// Description : Stochastic-to-binary converter. Counts ones of a unary
//               bitstream over 2^WINLOG enabled samples, saturates the count
//               to 2^WINLOG-1 and scales it to BITWIDTH bits. The result is
//               offered on a valid/ready handshake.
// Ports       : iClk    - clock
//               iRstN   - asynchronous active-low reset
//               iClr    - synchronous clear/abort (overrides start/ready)
//               iStart  - begin a conversion window
//               iEn     - sample qualifier for iBit
//               iBit    - unary bitstream input
//               oBusy   - window in progress
//               oValid  - result available
//               iReady  - consumer accepts result
//               oResult - converted binary value
// Revision    : 1.0 - initial release
// ============================================================================
module ucount_b2c
  import ucount_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int WINLOG   = 8   // must be >= BITWIDTH
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iStart,
  input  logic                iEn,
  input  logic                iBit,
  output logic                oBusy,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oResult
);

  localparam int unsigned    C_WIN   = win_len(WINLOG);
  localparam logic [WINLOG:0] C_MAX  = (WINLOG+1)'(C_WIN - 1);
  localparam logic [WINLOG-1:0] C_LAST = WINLOG'(C_WIN - 1);
  localparam int             C_SHIFT = WINLOG - BITWIDTH;

  state_t              state_q, state_d;
  logic [WINLOG-1:0]   cnt_smp_q, cnt_smp_d;
  logic [WINLOG:0]     cnt_one_q, cnt_one_d;
  logic                valid_q, valid_d;
  logic [BITWIDTH-1:0] result_q, result_d;

  // Ones count including the current sample, and its saturated form.
  // A full window of ones reaches 2^WINLOG, which must clamp rather than
  // wrap to zero once the MSB is dropped by scaling.
  logic [WINLOG:0]     ones_nxt;
  logic [WINLOG:0]     ones_sat;

  always_comb begin
    state_d   = state_q;
    cnt_smp_d = cnt_smp_q;
    cnt_one_d = cnt_one_q;
    valid_d   = valid_q;
    result_d  = result_q;

    ones_nxt = cnt_one_q + {{WINLOG{1'b0}}, iBit};
    ones_sat = ones_nxt[WINLOG] ? C_MAX : ones_nxt;

    if (iClr) begin
      state_d   = ST_IDLE;
      cnt_smp_d = '0;
      cnt_one_d = '0;
      valid_d   = 1'b0;
      result_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            state_d   = ST_ACCUM;
            cnt_smp_d = '0;
            cnt_one_d = '0;
          end
        end
        ST_ACCUM: begin
          if (iEn) begin
            cnt_smp_d = cnt_smp_q + 1'b1;
            cnt_one_d = ones_nxt;
            if (cnt_smp_q == C_LAST) begin
              state_d  = ST_HOLD;
              valid_d  = 1'b1;
              result_d = BITWIDTH'(ones_sat >> C_SHIFT);
            end
          end
        end
        ST_HOLD: begin
          if (iReady) begin
            valid_d = 1'b0;
            if (iStart) begin
              // back-to-back: skip IDLE and open the next window now
              state_d   = ST_ACCUM;
              cnt_smp_d = '0;
              cnt_one_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q   <= ST_IDLE;
      cnt_smp_q <= '0;
      cnt_one_q <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_smp_q <= cnt_smp_d;
      cnt_one_q <= cnt_one_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  assign oBusy   = (state_q == ST_ACCUM);
  assign oValid  = valid_q;
  assign oResult = result_q;

endmodule
`default_nettype wire

// File: doc/ucount_b2c.md
Name: ucount_b2c

Overview:
- Stochastic-to-binary converter; sits directly downstream of the unary multiplier and consumes its 1-bit product stream.
- Counts ones over a fixed window of 2^WINLOG enabled samples and scales the count to a BITWIDTH-bit binary result.
- Presents the result on a valid/ready handshake to the binary datapath.

Parameters:
- BITWIDTH, 8, width of the binary result.
- WINLOG, 8, log2 of the window length in samples. Constraint: WINLOG >= BITWIDTH.

Ports:
- iClk  input  1  clock
- iRstN  input  1  reset, asynchronous, active-low
- iClr  input  1  synchronous clear/abort; highest priority after reset
- iStart  input  1  start a conversion window
- iEn  input  1  sample qualifier; iBit counts only when iEn=1
- iBit  input  1  unary bitstream (multiplier product)
- oBusy  output  1  window in progress
- oValid  output  1  result available
- iReady  input  1  consumer accepts result
- oResult  output  BITWIDTH  converted binary value

Behaviour:
- Reset (async, iRstN=0): state IDLE; oBusy=0, oValid=0, oResult=0; internal counters 0.
- Internal counters: sample counter cnt_smp [WINLOG-1:0]; ones counter cnt_one [WINLOG:0], so 2^WINLOG is representable.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - iStart=1 -> ACCUM; both counters cleared on that edge.
  - The iBit on the iStart cycle is not counted.
- ACCUM (oBusy=1):
  - Each cycle with iEn=1: cnt_smp += 1; cnt_one += iBit.
  - iEn=0: counters hold, so the window stretches.
  - iStart is ignored.
  - When iEn=1 and cnt_smp == 2^WINLOG-1 (last sample): the last sample is included; next edge -> HOLD, oValid=1.
  - oResult = min(final_ones, 2^WINLOG-1) >> (WINLOG-BITWIDTH), registered on the same edge.
  - Latency: oValid rises on the clock edge that samples the 2^WINLOG-th enabled bit.
- HOLD (oValid=1, oBusy=0):
  - oResult stable while iReady=0.
  - On oValid & iReady: oValid drops next edge -> IDLE.
  - If iStart=1 in the same cycle -> ACCUM directly, with counters cleared (back-to-back conversions).
  - oResult keeps the last value until the next window completes.
- iClr=1 (any state): next edge -> IDLE; counters 0, oValid=0, oResult=0. iClr overrides iStart and iReady in the same cycle.
- Saturation: an all-ones window (2^WINLOG ones) yields all-ones oResult, never 0 from wrap-around.
- No X propagation: iBit is ignored outside ACCUM.

Decomposition:
- Shared package ucount_pkg:
  - state enum (IDLE, ACCUM, HOLD), 2-bit encoding.
  - localparam helper for the window length 2^WINLOG.
- Single module; no sub-module needed. The counters and the saturate/scale function are inline.

Test Plan:
- BITWIDTH=8, WINLOG=8, iEn=1, iBit=1 for 256 cycles after iStart -> oValid rises after the 256th sample; oResult=255 (saturated); oBusy=0 in HOLD.
- Same config, iBit=0 throughout -> oResult=0. iBit=1 every 4th cycle (64 ones) -> oResult=64.
- WINLOG=10, BITWIDTH=8, iBit alternating 1/0 (512 ones in 1024) -> oResult=128; window length 1024 enabled samples.
- iEn=1 on every other cycle, iBit=1 on enabled cycles, WINLOG=8 -> 512 clock cycles elapse before oValid; oResult=255; iBit pulses on iEn=0 cycles are not counted.
- Backpressure:
  - iReady=0 for 10 cycles in HOLD -> oValid and oResult held constant.
  - Then iReady=1 with iStart=1 -> next cycle oValid=0, oBusy=1, counters 0.
  - The following window with 128 ones -> oResult=128.
- Abort and reset:
  - iClr=1 at sample 100 of a window -> next cycle IDLE; oBusy=0, oValid=0, oResult=0.
  - iRstN pulled low mid-HOLD -> all outputs 0 immediately, with no clock edge required.
